// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET return sequencer for the rv32i pipeline.
// Optional drain watchdog compiled in with `define TRAP_SEQ_WATCHDOG_EN.
module trap_sequencer #(
    parameter int DRAIN_MAX = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq_pending_i,
    input  logic [31:0] trap_vec_i,
    input  logic        mret_i,
    input  logic [31:0] mret_pc_i,
    input  logic        pipe_empty_i,
    input  logic        mem_busy_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        oldest_valid_i,
    input  logic [31:0] oldest_pc_i,
    output logic        stall_fetch_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        trap_enter_o,
    output logic [31:0] trap_epc_o,
    output logic        mret_ack_o,
    output logic        busy_o
);
    // state | meaning
    // IDLE  | no trap activity, pipeline runs freely
    // DRAIN | interrupt pending, fetch stalled while older instructions retire
    // TRAP  | one cycle: pulse trap entry, flush, redirect to trap vector
    // MRET  | one cycle: pulse CSR restore, flush, redirect to mepc
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2,
        ST_MRET  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] epc_q, epc_nxt;
    logic [31:0] mret_pc_q, mret_pc_nxt;

`ifdef TRAP_SEQ_WATCHDOG_EN
    logic [7:0] cnt_q, cnt_nxt;
    logic       wd_fire;

    // Fires once this DRAIN cycle brings the completed-cycle count to DRAIN_MAX.
    assign wd_fire = ({1'b0, cnt_q} + 9'd1) >= 9'(DRAIN_MAX);
`else
    logic unused_watchdog;
    assign unused_watchdog = ^{oldest_valid_i, oldest_pc_i, 8'(DRAIN_MAX)};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            epc_q     <= 32'h0;
            mret_pc_q <= 32'h0;
`ifdef TRAP_SEQ_WATCHDOG_EN
            cnt_q     <= 8'h0;
`endif
        end else begin
            state     <= state_nxt;
            epc_q     <= epc_nxt;
            mret_pc_q <= mret_pc_nxt;
`ifdef TRAP_SEQ_WATCHDOG_EN
            cnt_q     <= cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt        = state;
        epc_nxt          = epc_q;
        mret_pc_nxt      = mret_pc_q;
`ifdef TRAP_SEQ_WATCHDOG_EN
        cnt_nxt          = cnt_q;
`endif
        stall_fetch_o    = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'h0;
        trap_enter_o     = 1'b0;
        trap_epc_o       = 32'h0;
        mret_ack_o       = 1'b0;
        busy_o           = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (mret_i) begin
                    state_nxt   = ST_MRET;
                    mret_pc_nxt = mret_pc_i;
                end else if (irq_pending_i) begin
                    state_nxt = ST_DRAIN;
`ifdef TRAP_SEQ_WATCHDOG_EN
                    cnt_nxt   = 8'h0;
`endif
                end
            end
            ST_DRAIN: begin
                stall_fetch_o = 1'b1;
                if (mret_i) begin
                    state_nxt   = ST_MRET;
                    mret_pc_nxt = mret_pc_i;
                end else if (!irq_pending_i) begin
                    state_nxt = ST_IDLE;
                end else if (pipe_empty_i && !mem_busy_i) begin
                    state_nxt = ST_TRAP;
                    epc_nxt   = fetch_pc_i;
`ifdef TRAP_SEQ_WATCHDOG_EN
                end else if (wd_fire && !mem_busy_i) begin
                    // Older instructions are flushed and replayed after MRET.
                    state_nxt = ST_TRAP;
                    epc_nxt   = oldest_valid_i ? oldest_pc_i : fetch_pc_i;
                end else if (cnt_q != 8'hFF) begin
                    cnt_nxt = cnt_q + 8'd1;
`endif
                end
            end
            ST_TRAP: begin
                stall_fetch_o    = 1'b1;
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = trap_vec_i;
                trap_enter_o     = 1'b1;
                trap_epc_o       = epc_q & 32'hFFFF_FFFE;
                state_nxt        = ST_IDLE;
            end
            ST_MRET: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = mret_pc_q & 32'hFFFF_FFFE;
                mret_ack_o       = 1'b1;
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed vector table, hand sequences,
// and random stimulus against an event-level reference model.
module tb_trap_sequencer;
    localparam int DMAX = 4;
    localparam int K_IDLE = 0, K_DRAIN = 1, K_TRAP = 2, K_MRET = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        irq = 1'b0, mret = 1'b0, empty = 1'b0, mbusy = 1'b0, ov = 1'b0;
    logic [31:0] vec = 32'h0, mpc = 32'h0, fetch = 32'h0, opc = 32'h0;
    logic        stall, flush, rv, te, ack, busy;
    logic [31:0] rpc, epc;

    trap_sequencer #(.DRAIN_MAX(DMAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .irq_pending_i(irq), .trap_vec_i(vec), .mret_i(mret), .mret_pc_i(mpc),
        .pipe_empty_i(empty), .mem_busy_i(mbusy), .fetch_pc_i(fetch),
        .oldest_valid_i(ov), .oldest_pc_i(opc),
        .stall_fetch_o(stall), .flush_o(flush), .redirect_valid_o(rv),
        .redirect_pc_o(rpc), .trap_enter_o(te), .trap_epc_o(epc),
        .mret_ack_o(ack), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        irq, mret, empty, mbusy;
        logic [31:0] vec, mpc, fetch;
        int          kind;
        logic [31:0] e_rpc, e_epc;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(logic i, logic m, logic e, logic b, logic [31:0] v,
                                logic [31:0] p, logic [31:0] f, int k,
                                logic [31:0] er, logic [31:0] ee);
        row_t r;
        r.irq = i; r.mret = m; r.empty = e; r.mbusy = b;
        r.vec = v; r.mpc = p; r.fetch = f; r.kind = k; r.e_rpc = er; r.e_epc = ee;
        return r;
    endfunction

    function automatic logic [69:0] outs();
        return {stall, flush, rv, rpc, te, epc, ack, busy};
    endfunction

    function automatic logic [69:0] expand(int k, logic [31:0] r, logic [31:0] e);
        case (k)
            K_DRAIN: return {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
            K_TRAP:  return {1'b1, 1'b1, 1'b1, r, 1'b1, e, 1'b0, 1'b1};
            K_MRET:  return {1'b0, 1'b1, 1'b1, r, 1'b0, 32'h0, 1'b1, 1'b1};
            default: return 70'h0;
        endcase
    endfunction

    task automatic check(string name, logic [69:0] act, logic [69:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got stall/flush/rv/rpc/te/epc/ack/busy=%0b/%0b/%0b/%h/%0b/%h/%0b/%0b expected %0b/%0b/%0b/%h/%0b/%h/%0b/%0b",
                     name, act[69], act[68], act[67], act[66:35], act[34], act[33:2], act[1], act[0],
                     exp_v[69], exp_v[68], exp_v[67], exp_v[66:35], exp_v[34], exp_v[33:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Reference model: tracks whether a trap is being waited for and which
    // one-cycle pulse (if any) is due, plus the PC that pulse carries.
    bit          m_wait;
    int          m_pulse;      // 0 none, 1 trap entry, 2 mret return
    logic [31:0] m_pc;
    int          m_drained;

    function automatic logic [69:0] model_exp();
        logic [31:0] pc_even;
        pc_even = m_pc & 32'hFFFF_FFFE;
        if (m_pulse == 1) return expand(K_TRAP, vec, pc_even);
        if (m_pulse == 2) return expand(K_MRET, pc_even, 32'h0);
        if (m_wait)       return expand(K_DRAIN, 32'h0, 32'h0);
        return 70'h0;
    endfunction

    task automatic model_step();
        if (m_pulse != 0) begin
            m_pulse = 0;
        end else if (mret) begin
            m_wait = 0; m_pulse = 2; m_pc = mpc;
        end else if (m_wait) begin
            if (!irq) begin
                m_wait = 0;
            end else if (empty && !mbusy) begin
                m_wait = 0; m_pulse = 1; m_pc = fetch;
            end else begin
                m_drained++;
`ifdef TRAP_SEQ_WATCHDOG_EN
                if (m_drained >= DMAX && !mbusy) begin
                    m_wait = 0; m_pulse = 1; m_pc = ov ? opc : fetch;
                end
`endif
            end
        end else if (irq) begin
            m_wait = 1; m_drained = 0;
        end
    endtask

    task automatic drive(logic i, logic m, logic e, logic b, logic [31:0] v,
                         logic [31:0] p, logic [31:0] f);
        irq = i; mret = m; empty = e; mbusy = b; vec = v; mpc = p; fetch = f;
    endtask

    initial begin
        // Idle pipe trap entry
        tbl.push_back(mk(1,0,1,0,32'h100,32'h0, 32'h40,K_IDLE, 0,0));
        tbl.push_back(mk(1,0,1,0,32'h100,32'h0, 32'h40,K_DRAIN,0,0));
        tbl.push_back(mk(0,0,1,0,32'h100,32'h0, 32'h40,K_TRAP, 32'h100,32'h40));
        tbl.push_back(mk(0,0,1,0,32'h100,32'h0, 32'h40,K_IDLE, 0,0));
        // MRET beats a same-cycle interrupt
        tbl.push_back(mk(1,1,1,0,32'h100,32'h84,32'h40,K_IDLE, 0,0));
        tbl.push_back(mk(1,0,1,0,32'h100,32'h84,32'h40,K_MRET, 32'h84,0));
        tbl.push_back(mk(0,0,1,0,32'h100,32'h84,32'h40,K_IDLE, 0,0));
        // Interrupt withdrawn during drain
        tbl.push_back(mk(1,0,0,0,32'h100,32'h0, 32'h40,K_IDLE, 0,0));
        tbl.push_back(mk(1,0,0,0,32'h100,32'h0, 32'h40,K_DRAIN,0,0));
        tbl.push_back(mk(1,0,0,0,32'h100,32'h0, 32'h40,K_DRAIN,0,0));
        tbl.push_back(mk(1,0,0,0,32'h100,32'h0, 32'h40,K_DRAIN,0,0));
        tbl.push_back(mk(0,0,0,0,32'h100,32'h0, 32'h40,K_DRAIN,0,0));
        tbl.push_back(mk(0,0,0,0,32'h100,32'h0, 32'h40,K_IDLE, 0,0));
        // Odd mepc is aligned on return
        tbl.push_back(mk(0,1,0,0,32'h100,32'h85,32'h40,K_IDLE, 0,0));
        tbl.push_back(mk(0,0,0,0,32'h100,32'h85,32'h40,K_MRET, 32'h84,0));
        tbl.push_back(mk(0,0,0,0,32'h100,32'h85,32'h40,K_IDLE, 0,0));
        // MRET arriving while draining
        tbl.push_back(mk(1,0,0,0,32'h100,32'h0, 32'h40,K_IDLE, 0,0));
        tbl.push_back(mk(1,1,0,0,32'h100,32'h200,32'h40,K_DRAIN,0,0));
        tbl.push_back(mk(1,0,1,0,32'h100,32'h200,32'h40,K_MRET,32'h200,0));
        // Busy memory holds drain; odd fetch PC aligned; live trap vector
        tbl.push_back(mk(1,0,1,1,32'h100,32'h0, 32'h40,K_IDLE, 0,0));
        tbl.push_back(mk(1,0,1,1,32'h100,32'h0, 32'h40,K_DRAIN,0,0));
        tbl.push_back(mk(1,0,1,0,32'h300,32'h0, 32'h41,K_DRAIN,0,0));
        tbl.push_back(mk(0,0,1,0,32'h304,32'h0, 32'h41,K_TRAP, 32'h304,32'h40));
        tbl.push_back(mk(0,0,1,0,32'h304,32'h0, 32'h41,K_IDLE, 0,0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), 70'h0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].irq, tbl[i].mret, tbl[i].empty, tbl[i].mbusy,
                  tbl[i].vec, tbl[i].mpc, tbl[i].fetch);
            #1;
            check($sformatf("vec_row%0d", i), outs(),
                  expand(tbl[i].kind, tbl[i].e_rpc, tbl[i].e_epc));
        end

`ifdef TRAP_SEQ_WATCHDOG_EN
        begin
            int  n_drain;
            bit  got;
            logic [31:0] got_epc;
            @(negedge clk);
            drive(1, 0, 0, 0, 32'h100, 32'h0, 32'h40);
            ov = 1'b1; opc = 32'h200;
            n_drain = 0; got = 0; got_epc = 32'h0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(posedge clk); @(negedge clk); #1;
                if (te) begin got = 1; got_epc = epc; end
                else if (stall) n_drain++;
            end
            check_val("wd_fired", 32'(got), 32'd1);
            check_val("wd_drain_cycles", 32'(n_drain), 32'(DMAX));
            check_val("wd_epc", got_epc, 32'h200);
            irq = 1'b0;
            @(posedge clk); @(negedge clk);

            got = 0;
            drive(1, 0, 0, 1, 32'h100, 32'h0, 32'h40);
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); @(negedge clk); #1;
                if (te) got = 1;
            end
            check_val("wd_busy_defers", 32'(got), 32'd0);
            mbusy = 1'b0;
            @(posedge clk); @(negedge clk); #1;
            check_val("wd_after_busy_te", 32'(te), 32'd1);
            check_val("wd_after_busy_epc", epc, 32'h200);
            irq = 1'b0; ov = 1'b0;
            @(posedge clk);
        end
`endif

        // Reset asserted during TRAP
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h100, 32'h0, 32'h48);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        irq = 1'b0;
        #1;
        check("rst_pre_trap", outs(), expand(K_TRAP, 32'h100, 32'h48));
        reset_n = 1'b0;
        #1;
        check("rst_in_trap", outs(), 70'h0);
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_released", outs(), 70'h0);
        @(posedge clk); @(negedge clk); #1;
        check("rst_idle_after", outs(), 70'h0);

        // Randomized run against the reference model (DUT idle here)
        m_wait = 0; m_pulse = 0; m_pc = 32'h0; m_drained = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            irq   = ($urandom_range(0, 2) == 0);
            mret  = ($urandom_range(0, 7) == 0);
            empty = ($urandom_range(0, 3) == 0);
            mbusy = ($urandom_range(0, 3) == 0);
            ov    = $urandom_range(0, 1) == 1;
            vec   = $urandom;
            mpc   = $urandom;
            fetch = $urandom;
            opc   = $urandom;
            #1;
            check($sformatf("rand_cyc%0d", c), outs(), model_exp());
            @(posedge clk);
            model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Sequences machine-mode trap entry and MRET return around the CSR file for the rv32i pipeline. When the CSR file reports an enabled, pending interrupt, the block stalls fetch and drains older instructions. It then captures a precise exception PC, pulses trap entry into the CSR file, flushes the pipeline and redirects fetch to the trap vector. For MRET it flushes younger instructions, redirects to mepc and pulses the CSR restore. It replaces ad-hoc PC capture inside the CSR file with one owner of trap sequencing.

## Interface
- DRAIN_MAX, 15: max DRAIN cycles before the watchdog forces trap entry (only with watchdog compiled in); range 1..255.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- irq_pending_i  in  1  mstatus.MIE & mie.MTIE & mip.MTIP from CSR file, combinational from CSR registers.
- trap_vec_i  in  32  trap target computed by CSR file (direct/vectored).
- mret_i  in  1  MRET instruction valid in EX stage.
- mret_pc_i  in  32  current mepc.
- pipe_empty_i  in  1  no valid instruction in ID, EX, MEM, WB.
- mem_busy_i  in  1  data-memory transaction outstanding (cannot be aborted).
- fetch_pc_i  in  32  PC held in IF (next instruction to issue).
- oldest_valid_i  in  1  a valid uncommitted instruction exists in ID..MEM.
- oldest_pc_i  in  32  PC of that oldest instruction.
- stall_fetch_o  out  1  hold IF PC, inject bubbles into ID.
- flush_o  out  1  kill ID, EX, MEM same cycle (MEM write enables gated combinationally).
- redirect_valid_o  out  1  load redirect_pc_o into PC.
- redirect_pc_o  out  32  redirect target.
- trap_enter_o  out  1  pulse: CSR file saves mepc/mcause, MPIE<=MIE, MIE<=0.
- trap_epc_o  out  32  value for mepc, bit 0 forced 0.
- mret_ack_o  out  1  pulse: CSR file MIE<=MPIE, MPIE<=1.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, DRAIN, TRAP, MRET. Reset: IDLE, all outputs 0, latched PCs 0, watchdog counter 0.
- IDLE: mret_i -> MRET, latch mret_pc_i. Else irq_pending_i -> DRAIN, clear counter. mret_i has priority over irq_pending_i.
- DRAIN: stall_fetch_o=1.
  - mret_i -> MRET, latch mret_pc_i. The interrupt is re-evaluated after return from IDLE.
  - Else !irq_pending_i (a draining CSR write cleared MIE/MTIE) -> IDLE, no trap.
  - Else pipe_empty_i & !mem_busy_i -> TRAP, latch epc=fetch_pc_i.
  - Else counter increments (saturating).
- TRAP (1 cycle): trap_enter_o=1, flush_o=1, redirect_valid_o=1, redirect_pc_o=trap_vec_i, trap_epc_o=latched epc & 32'hFFFF_FFFE, stall_fetch_o=1 -> IDLE.
- MRET (1 cycle): mret_ack_o=1, flush_o=1, redirect_valid_o=1, redirect_pc_o=latched mret_pc & 32'hFFFF_FFFE -> IDLE. The MRET itself proceeds to WB (no side effects).
- trap_vec_i is sampled in TRAP, not latched. A CSR write to mtvec cannot be in flight in TRAP.
- Outputs trap_epc_o/redirect_pc_o are 0 whenever their valid pulse is low.

## Timing
- irq_pending_i high at edge N (IDLE) -> DRAIN from N+1. Minimum trap latency: pipe empty at N+1 -> TRAP at N+2 -> handler fetch at N+3.
- mret_i at edge N -> MRET cycle N+1 -> target fetched N+2.
- All outputs are state-decoded from registers, so there are no combinational input-to-output paths except redirect_pc_o from trap_vec_i.
- After TRAP, MIE=0 at the next edge, so irq_pending_i is low in IDLE and no back-to-back re-entry occurs.
- Reset asserted mid-DRAIN/TRAP/MRET: immediate IDLE, pulses drop the same cycle.

## Configuration
- TRAP_SEQ_WATCHDOG_EN defined: in DRAIN, when the counter reaches DRAIN_MAX and !mem_busy_i -> TRAP.
  - epc = oldest_valid_i ? oldest_pc_i : fetch_pc_i.
  - Older uncommitted instructions are flushed and re-executed after MRET.
  - mem_busy_i high always defers the watchdog.
- Undefined: there is no counter. DRAIN waits indefinitely for pipe_empty_i & !mem_busy_i.

## Test plan
- Idle pipe, trap_vec_i=0x100, fetch_pc_i=0x40, raise irq_pending_i -> one-cycle trap_enter_o with trap_epc_o=0x40, redirect to 0x100 two cycles after raise, busy_o low after.
- irq_pending_i and mret_i same cycle, mret_pc_i=0x84 -> MRET path only: mret_ack_o pulse, redirect 0x84, no trap_enter_o that cycle.
- DRAIN with pipe_empty_i low 3 cycles, then irq_pending_i drops -> return to IDLE, stall released, no flush, no trap_enter_o.
- Watchdog (macro on, DRAIN_MAX=4): pipe never empties, oldest_pc_i=0x200 -> trap after 4 DRAIN cycles with epc=0x200. With mem_busy_i held high -> no trap until it drops.
- mret_pc_i=0x85 -> redirect_pc_o=0x84. Reset asserted in TRAP -> all outputs 0 immediately, IDLE after release.
